// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Two-slot (EXE/MEM) register-write scoreboard producing the ID
//            stage hazard/stall, a pending-write mask and an optional stall
//            counter (enabled by macro HAZARD_STATS_EN).
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        flush,
    input  logic        forward_en,
    input  logic        id_valid,
    input  logic [3:0]  src1,
    input  logic [3:0]  src2,
    input  logic        two_src,
    input  logic        use_src1,
    input  logic [3:0]  dest_id,
    input  logic        wb_en_id,
    input  logic        mem_r_en_id,
    output logic        hazard,
    output logic [15:0] pending,
    output logic [15:0] stall_count
);

    logic       r_exe_valid;
    logic [3:0] r_exe_dest;
    logic       r_exe_wb_en;
    logic       r_exe_mem_r_en;
    logic       r_mem_valid;
    logic [3:0] r_mem_dest;
    logic       r_mem_wb_en;
    logic       r_mem_mem_r_en;

    logic w_used1;
    logic w_used2;
    logic w_exe_m1;
    logic w_exe_m2;
    logic w_mem_m1;
    logic w_mem_m2;
    logic w_bubble;
    logic w_unused_mem_load;

    assign w_used1  = id_valid & use_src1;
    assign w_used2  = id_valid & two_src;

    assign w_exe_m1 = r_exe_valid & r_exe_wb_en & (r_exe_dest == src1);
    assign w_exe_m2 = r_exe_valid & r_exe_wb_en & (r_exe_dest == src2);
    assign w_mem_m1 = r_mem_valid & r_mem_wb_en & (r_mem_dest == src1);
    assign w_mem_m2 = r_mem_valid & r_mem_wb_en & (r_mem_dest == src2);

    // With forwarding only a load still in EXE cannot supply its data in time.
    always_comb begin
        hazard = 1'b0;
        if (forward_en) begin
            hazard = r_exe_mem_r_en & ((w_used1 & w_exe_m1) | (w_used2 & w_exe_m2));
        end else begin
            hazard = (w_used1 & (w_exe_m1 | w_mem_m1)) | (w_used2 & (w_exe_m2 | w_mem_m2));
        end
    end

    always_comb begin
        pending = 16'h0000;
        if (r_exe_valid && r_exe_wb_en) begin
            pending[r_exe_dest] = 1'b1;
        end
        if (r_mem_valid && r_mem_wb_en) begin
            pending[r_mem_dest] = 1'b1;
        end
    end

    assign w_bubble = hazard | flush | ~id_valid;

    // The MEM load flag is tracked for slot completeness; no decision needs it.
    assign w_unused_mem_load = r_mem_mem_r_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_exe_valid    <= 1'b0;
            r_exe_dest     <= 4'h0;
            r_exe_wb_en    <= 1'b0;
            r_exe_mem_r_en <= 1'b0;
            r_mem_valid    <= 1'b0;
            r_mem_dest     <= 4'h0;
            r_mem_wb_en    <= 1'b0;
            r_mem_mem_r_en <= 1'b0;
        end else if (!freeze) begin
            r_mem_valid    <= r_exe_valid;
            r_mem_dest     <= r_exe_dest;
            r_mem_wb_en    <= r_exe_wb_en;
            r_mem_mem_r_en <= r_exe_mem_r_en;
            if (w_bubble) begin
                r_exe_valid    <= 1'b0;
                r_exe_dest     <= 4'h0;
                r_exe_wb_en    <= 1'b0;
                r_exe_mem_r_en <= 1'b0;
            end else begin
                r_exe_valid    <= 1'b1;
                r_exe_dest     <= dest_id;
                r_exe_wb_en    <= wb_en_id;
                r_exe_mem_r_en <= mem_r_en_id;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    localparam logic [15:0] c_stall_max = 16'hFFFF;

    logic [15:0] r_stall_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_count <= 16'h0000;
        end else if (!freeze && hazard && (r_stall_count != c_stall_max)) begin
            r_stall_count <= r_stall_count + 16'h0001;
        end
    end

    assign stall_count = r_stall_count;
`else
    assign stall_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Table-driven plus sequence bench for hazard_scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

`ifdef HAZARD_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif
    localparam int NV = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze, flush, forward_en, id_valid;
    logic [3:0]  src1, src2, dest_id;
    logic        two_src, use_src1, wb_en_id, mem_r_en_id;
    logic        hazard;
    logic [15:0] pending, stall_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        in_exe;
        logic [3:0]  pdest;
        logic        pwb;
        logic        pld;
        logic        fwd;
        logic        idv;
        logic        use1;
        logic        two;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic        exp_hz;
        logic [15:0] exp_pend;
    } vec_t;

    typedef struct {
        logic        hz;
        logic [15:0] pend;
    } exp_t;

    vec_t vecs [NV];
    exp_t sb [$];

    hazard_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .flush       (flush),
        .forward_en  (forward_en),
        .id_valid    (id_valid),
        .src1        (src1),
        .src2        (src2),
        .two_src     (two_src),
        .use_src1    (use_src1),
        .dest_id     (dest_id),
        .wb_en_id    (wb_en_id),
        .mem_r_en_id (mem_r_en_id),
        .hazard      (hazard),
        .pending     (pending),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        freeze = 1'b0; flush = 1'b0; id_valid = 1'b0;
        src1 = 4'h0; src2 = 4'h0; two_src = 1'b0; use_src1 = 1'b0;
        dest_id = 4'h0; wb_en_id = 1'b0; mem_r_en_id = 1'b0;
    endtask

    task automatic issue(input logic [3:0] d, input logic wb, input logic ld);
        idle();
        id_valid = 1'b1; dest_id = d; wb_en_id = wb; mem_r_en_id = ld;
    endtask

    task automatic id_reads(input logic [3:0] a, input logic ua, input logic [3:0] b, input logic ub,
                            input logic [3:0] d, input logic wb);
        id_valid = 1'b1; src1 = a; use_src1 = ua; src2 = b; two_src = ub;
        dest_id = d; wb_en_id = wb; mem_r_en_id = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle();
        #2;
        rst = 1'b1;
    endtask

    initial begin
        exp_t e;
        //          in_exe pdest  pwb   pld   fwd   idv   use1  two   s1     s2     hz    pend
        vecs[0]  = '{1'b1, 4'd3,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3,  4'd0,  1'b1, 16'h0008};
        vecs[1]  = '{1'b1, 4'd3,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  4'd3,  1'b0, 16'h0008};
        vecs[2]  = '{1'b1, 4'd3,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0,  4'd3,  1'b1, 16'h0008};
        vecs[3]  = '{1'b1, 4'd3,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3,  4'd0,  1'b0, 16'h0008};
        vecs[4]  = '{1'b1, 4'd3,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3,  4'd0,  1'b1, 16'h0008};
        vecs[5]  = '{1'b0, 4'd3,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0,  4'd3,  1'b1, 16'h0008};
        vecs[6]  = '{1'b0, 4'd3,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3,  4'd0,  1'b0, 16'h0008};
        vecs[7]  = '{1'b1, 4'd5,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd3,  4'd4,  1'b0, 16'h0020};
        vecs[8]  = '{1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3,  4'd0,  1'b0, 16'h0000};
        vecs[9]  = '{1'b1, 4'd3,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3,  4'd3,  1'b0, 16'h0008};
        vecs[10] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  4'd0,  1'b1, 16'h0001};
        vecs[11] = '{1'b0, 4'd12, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5,  4'd12, 1'b1, 16'h1000};

        rst = 1'b0;
        forward_en = 1'b1;
        idle();
        #3;
        check("reset hazard", {15'b0, hazard}, 16'h0000);
        check("reset pending", pending, 16'h0000);
        check("reset stall_count", stall_count, 16'h0000);
        @(negedge clk);
        rst = 1'b1;

        // Table: place one producer in EXE or MEM, then present ID readers.
        for (int i = 0; i < NV; i++) begin
            idle(); step(); step();
            issue(vecs[i].pdest, vecs[i].pwb, vecs[i].pld);
            step();
            if (!vecs[i].in_exe) begin
                idle(); step();
            end
            forward_en = vecs[i].fwd;
            id_reads(vecs[i].s1, vecs[i].use1, vecs[i].s2, vecs[i].two, 4'hF, 1'b0);
            id_valid = vecs[i].idv;
            sb.push_back('{vecs[i].exp_hz, vecs[i].exp_pend});
            #1;
            if (sb.size() == 0) begin
                check($sformatf("vec%0d scoreboard empty", i), 16'h0001, 16'h0000);
            end else begin
                e = sb.pop_front();
                check($sformatf("vec%0d hazard", i), {15'b0, hazard}, {15'b0, e.hz});
                check($sformatf("vec%0d pending", i), pending, e.pend);
            end
        end

        // Load-use: one stall cycle, then the ADD enters EXE.
        do_reset();
        forward_en = 1'b1;
        issue(4'd3, 1'b1, 1'b1); step();
        id_reads(4'd3, 1'b1, 4'd1, 1'b1, 4'd4, 1'b1);
        #1;
        check("ldr-add hazard c0", {15'b0, hazard}, 16'h0001);
        check("ldr-add pending c0", pending, 16'h0008);
        step();
        check("ldr-add hazard c1", {15'b0, hazard}, 16'h0000);
        check("ldr-add pending c1", pending, 16'h0008);
        step();
        check("ldr-add pending c2", pending, 16'h0010);
        check("ldr-add stall_count", stall_count, 16'(STATS));

        // ALU producer: free with forwarding, two stall cycles without.
        do_reset();
        forward_en = 1'b1;
        issue(4'd3, 1'b1, 1'b0); step();
        id_reads(4'd3, 1'b1, 4'd2, 1'b1, 4'd5, 1'b1);
        #1;
        check("add-sub fwd hazard", {15'b0, hazard}, 16'h0000);
        forward_en = 1'b0;
        #1;
        check("add-sub nofwd hazard c0", {15'b0, hazard}, 16'h0001);
        step();
        check("add-sub nofwd hazard c1", {15'b0, hazard}, 16'h0001);
        step();
        check("add-sub nofwd hazard c2", {15'b0, hazard}, 16'h0000);
        step();
        check("add-sub pending", pending, 16'h0020);
        check("add-sub stall_count", stall_count, 16'(2 * STATS));

        // Freeze holds slots and counter while hazard is still driven.
        do_reset();
        forward_en = 1'b1;
        issue(4'd7, 1'b1, 1'b1); step();
        freeze = 1'b1;
        id_reads(4'd7, 1'b1, 4'd0, 1'b0, 4'd9, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("freeze pending c%0d", k), pending, 16'h0080);
            check($sformatf("freeze hazard c%0d", k), {15'b0, hazard}, 16'h0001);
            check($sformatf("freeze stall_count c%0d", k), stall_count, 16'h0000);
        end
        idle(); step();
        check("unfreeze pending c0", pending, 16'h0080);
        step();
        check("unfreeze pending c1", pending, 16'h0000);

        // Flush squashes the ID write; flush with hazard counts once.
        do_reset();
        forward_en = 1'b1;
        issue(4'd2, 1'b1, 1'b0);
        flush = 1'b1;
        step();
        idle();
        #1;
        check("flush pending", pending, 16'h0000);
        issue(4'd3, 1'b1, 1'b1); step();
        id_reads(4'd3, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1);
        flush = 1'b1;
        #1;
        check("flush+hazard hazard", {15'b0, hazard}, 16'h0001);
        step();
        idle();
        #1;
        check("flush+hazard pending", pending, 16'h0008);
        check("flush+hazard stall_count", stall_count, 16'(STATS));

        // Asynchronous reset in the middle of a stall.
        idle(); step(); step();
        issue(4'd3, 1'b1, 1'b1); step();
        issue(4'd11, 1'b1, 1'b1); step();
        id_reads(4'd11, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        #1;
        check("pre-reset hazard", {15'b0, hazard}, 16'h0001);
        check("pre-reset pending", pending, 16'h0808);
        rst = 1'b0;
        #1;
        check("async reset hazard", {15'b0, hazard}, 16'h0000);
        check("async reset pending", pending, 16'h0000);
        check("async reset stall_count", stall_count, 16'h0000);
        issue(4'd6, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        step();
        check("post-reset first sample", pending, 16'h0040);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have port rst, input, 1, a reset that is asynchronous and active-low.
REQ-003 The block SHALL have port freeze, input, 1, a memory-wait stall that holds all scoreboard state.
REQ-004 The block SHALL have port flush, input, 1, a taken branch that squashes the ID instruction.
REQ-005 The block SHALL have port forward_en, input, 1, which is 1 when the forwarding path is active.
REQ-006 The block SHALL have port id_valid, input, 1, which marks a real instruction in ID.
REQ-007 The block SHALL have ports src1 and src2, input, 4 each, the ID source register numbers.
REQ-008 The block SHALL have port two_src, input, 1, which is 1 when src2 is read.
REQ-009 The block SHALL have port use_src1, input, 1, which is 1 when src1 is read.
REQ-010 The block SHALL have port dest_id, input, 4, the ID destination register.
REQ-011 The block SHALL have port wb_en_id, input, 1, which is 1 when the ID instruction writes a register.
REQ-012 The block SHALL have port mem_r_en_id, input, 1, which is 1 when the ID instruction is a load.
REQ-013 The block SHALL have port hazard, output, 1, which stalls IF/ID and forces a bubble into EXE.
REQ-014 The block SHALL have port pending, output, 16, where bit r is set when register r has an in-flight write in EXE or MEM.
REQ-015 The block SHALL have port stall_count, output, 16, the saturating count of hazard cycles (see Configuration).

Function
REQ-016 The block SHALL keep two tracked slots, EXE and MEM, each holding valid, dest[3:0], wb_en and mem_r_en.
REQ-017 A slot SHALL match src when valid & wb_en & (dest == src).
REQ-018 The block SHALL define used1 as id_valid & use_src1, and used2 as id_valid & two_src.
REQ-019 With forward_en=1, hazard SHALL equal EXE.mem_r_en & ((used1 & EXE matches src1) | (used2 & EXE matches src2)), i.e. load-use only.
REQ-020 With forward_en=0, hazard SHALL be asserted when either used source matches the EXE slot or the MEM slot.
REQ-021 The hazard output SHALL be combinational from the current slots and ID inputs, with zero-cycle latency.
REQ-022 The block SHALL NOT treat a WB-stage write as a hazard, because the register file writes on the first half-cycle.
REQ-023 When freeze=1, the EXE slot, MEM slot and stall_count SHALL all hold their values.
REQ-024 While freeze=1, hazard SHALL still be evaluated and driven.
REQ-025 When freeze=0, MEM SHALL take the EXE contents on the clock edge.
REQ-026 When freeze=0, EXE SHALL take a bubble (all fields 0) if hazard | flush | ~id_valid.
REQ-027 When freeze=0 and no bubble condition holds, EXE SHALL take {1, dest_id, wb_en_id, mem_r_en_id}.
REQ-028 When flush and hazard are asserted together, the bubble SHALL be inserted once and no hazard is counted twice.
REQ-029 pending SHALL be the OR of the one-hot decode of dest for every slot with valid & wb_en; both slots writing the same register set a single bit.
REQ-030 A load followed by a dependent instruction under forward_en=1 SHALL stall exactly 1 cycle, then proceed, with MEM data forwarded externally.

Reset
REQ-031 Asserting rst low SHALL immediately clear both slots, so that hazard=0, pending=0 and stall_count=0.
REQ-032 Reset asserted mid-stall SHALL drop hazard in the same cycle.
REQ-033 The first clock edge after rst is released SHALL sample ID normally.

Configuration
REQ-034 With macro HAZARD_STATS_EN defined, stall_count SHALL increment on each rising edge where hazard=1 and freeze=0, saturating at 16'hFFFF.
REQ-035 Without HAZARD_STATS_EN, stall_count SHALL be tied to 16'h0000 and no counter register shall exist.

Verification
REQ-036 Scenario LDR R3 then ADD R4,R3,R1 with forward_en=1: hazard=1 for exactly 1 cycle, then EXE holds the ADD, and stall_count=1.
REQ-037 Scenario ADD R3 then SUB R5,R3,R2 with forward_en=1: hazard=0 throughout; with forward_en=0: hazard=1 for 2 cycles.
REQ-038 Scenario LDR R3 in EXE with ID src2=R3 but two_src=0: hazard=0.
REQ-039 Scenario freeze=1 for 3 cycles with LDR R7 in EXE: pending=16'h0080 held, slots unchanged, and stall_count unchanged.
REQ-040 Scenario flush=1 with ADD R2 in ID: the next cycle has EXE invalid, and pending bit 2 stays clear.
REQ-041 Scenario rst low while hazard=1 and pending=16'h0808: hazard, pending and stall_count are all 0 before the next clock edge.
